// File: rtl/pid_sequencer.sv
// Loop scheduler for the PID controller: period tick -> SPI read -> PID strobe -> SPI write,
// with overrun detection, per-phase timeouts and status counters.
module pid_sequencer #(
    parameter int PERIOD_BITS = 12,
    parameter int PID_LAT     = 2,
    parameter int TIMEOUT     = 63
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic                   clr_status,
    output logic                   in_start,
    input  logic                   in_done,
    output logic                   pid_stb,
    output logic                   out_start,
    input  logic                   out_done,
    output logic                   busy,
    output logic                   overrun,
    output logic                   timeout_err,
    output logic [3:0]             overrun_cnt,
    output logic [7:0]             sample_cnt
);
    typedef enum logic [2:0] {IDLE, WAIT, READ, COMPUTE, WRITE} state_e;

    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT);
    localparam logic [3:0] PID_LAT_W = 4'(PID_LAT);

    state_e                 state_q, state_d;
    logic [PERIOD_BITS-1:0] period_cnt_q, period_cnt_d;
    logic [7:0]             wait_q, wait_d;
    logic [3:0]             lat_q, lat_d;
    logic                   in_start_q, in_start_d;
    logic                   pid_stb_q, pid_stb_d;
    logic                   out_start_q, out_start_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   timeout_err_q, timeout_err_d;
    logic [3:0]             overrun_cnt_q, overrun_cnt_d;
    logic [7:0]             sample_cnt_q, sample_cnt_d;
    logic                   tick, phase_busy, done_evt, tmo_evt;

    always_comb begin
        // NOTE: every _d gets a default first, so no branch can leave one unassigned and infer a latch.
        state_d       = state_q;
        wait_d        = wait_q;
        lat_d         = lat_q;
        in_start_d    = 1'b0;
        pid_stb_d     = 1'b0;
        out_start_d   = 1'b0;
        done_evt      = 1'b0;
        tmo_evt       = 1'b0;

        tick         = (period_cnt_q == '0) && (state_q != IDLE);
        phase_busy   = state_q inside {READ, COMPUTE, WRITE};
        period_cnt_d = (state_q == IDLE || period_cnt_q == '0) ? period
                                                               : period_cnt_q - PERIOD_BITS'(1);

        // The wait counter holds at 0 through the start-pulse cycle, so it reads 0 the cycle after.
        case (state_q)
            IDLE: if (enable) state_d = WAIT;
            WAIT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (tick) begin
                    state_d    = READ;
                    in_start_d = 1'b1;
                    wait_d     = '0;
                end
            end
            READ: begin
                if (in_done) begin
                    state_d   = COMPUTE;
                    pid_stb_d = 1'b1;
                    lat_d     = '0;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = WAIT;
                    tmo_evt = 1'b1;
                end else if (!in_start_q) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            COMPUTE: begin
                if (lat_q == PID_LAT_W) begin
                    state_d     = WRITE;
                    out_start_d = 1'b1;
                    wait_d      = '0;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            WRITE: begin
                if (out_done) begin
                    state_d  = WAIT;
                    done_evt = 1'b1;
                end else if (wait_q == TIMEOUT_W) begin
                    state_d = WAIT;
                    tmo_evt = 1'b1;
                end else if (!out_start_q) begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = state_d inside {READ, COMPUTE, WRITE};

        // A clear loses to any event landing in the same cycle.
        overrun_d     = clr_status ? 1'b0 : overrun_q;
        timeout_err_d = clr_status ? 1'b0 : timeout_err_q;
        overrun_cnt_d = clr_status ? 4'd0 : overrun_cnt_q;
        sample_cnt_d  = clr_status ? 8'd0 : sample_cnt_q;
        if (tick && phase_busy) begin
            overrun_d = 1'b1;
            if (clr_status)                overrun_cnt_d = 4'd1;
            else if (overrun_cnt_q != 4'hf) overrun_cnt_d = overrun_cnt_q + 4'd1;
        end
        if (tmo_evt)  timeout_err_d = 1'b1;
        if (done_evt) sample_cnt_d  = sample_cnt_q + 8'd1;
    end

    // NOTE: all flops update with <= so every one samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            period_cnt_q  <= period;
            wait_q        <= '0;
            lat_q         <= '0;
            in_start_q    <= 1'b0;
            pid_stb_q     <= 1'b0;
            out_start_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_cnt_q <= '0;
            sample_cnt_q  <= '0;
        end else begin
            state_q       <= state_d;
            period_cnt_q  <= period_cnt_d;
            wait_q        <= wait_d;
            lat_q         <= lat_d;
            in_start_q    <= in_start_d;
            pid_stb_q     <= pid_stb_d;
            out_start_q   <= out_start_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
            overrun_cnt_q <= overrun_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
        end
    end

    assign in_start    = in_start_q;
    assign pid_stb     = pid_stb_q;
    assign out_start   = out_start_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_err_q;
    assign overrun_cnt = overrun_cnt_q;
    assign sample_cnt  = sample_cnt_q;
endmodule

// File: tb/tb_pid_sequencer.sv
// Self-checking bench for pid_sequencer: bench-side SPI/PID responders plus a
// transaction-level model built from tick times and per-transaction busy spans.
module tb_pid_sequencer;
    localparam int PERIOD_BITS = 12;
    localparam int PID_LAT     = 2;
    localparam int TIMEOUT     = 63;

    typedef int iq_t[$];

    logic                   clk = 1'b0;
    logic                   reset, enable, clr_status, in_done, out_done;
    logic [PERIOD_BITS-1:0] period;
    logic                   in_start, pid_stb, out_start, busy, overrun, timeout_err;
    logic [3:0]             overrun_cnt;
    logic [7:0]             sample_cnt;

    pid_sequencer #(.PERIOD_BITS(PERIOD_BITS), .PID_LAT(PID_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .period(period), .clr_status(clr_status),
        .in_start(in_start), .in_done(in_done), .pid_stb(pid_stb), .out_start(out_start),
        .out_done(out_done), .busy(busy), .overrun(overrun), .timeout_err(timeout_err),
        .overrun_cnt(overrun_cnt), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int in_lat = 0, out_lat = 0, in_cd = 0, out_cd = 0;
    iq_t got_start, got_pid, got_out;
    iq_t exp_start, exp_pid, exp_out, exp_ovr_tick;
    int exp_ovr, exp_smp, exp_tmo, exp_busy;
    int acc_ovr, acc_smp, acc_tmo;

    // Responders (latency 0 = never answer) and pulse recorder, acting on the falling edge.
    initial begin
        in_done = 1'b0;
        out_done = 1'b0;
        forever begin
            @(negedge clk);
            in_done = 1'b0;
            out_done = 1'b0;
            if (in_cd > 0) begin in_cd--; if (in_cd == 0) in_done = 1'b1; end
            if (out_cd > 0) begin out_cd--; if (out_cd == 0) out_done = 1'b1; end
            if (in_start === 1'b1) begin got_start.push_back(cyc); in_cd = in_lat; end
            if (pid_stb === 1'b1) got_pid.push_back(cyc);
            if (out_start === 1'b1) begin got_out.push_back(cyc); out_cd = out_lat; end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic goto(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic clear_q();
        got_start.delete();
        got_pid.delete();
        got_out.delete();
    endtask

    task automatic cmp_queue(input string tag, input iq_t got, input iq_t exp);
        check({tag, " count"}, 32'(got.size()), 32'(exp.size()));
        foreach (exp[i])
            check($sformatf("%s[%0d]", tag, i), (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    // Ticks fall every p+1 cycles from the first WAIT cycle w. A tick that lands while a
    // transaction is busy is an overrun; otherwise it launches a transaction whose busy
    // span follows from the responder latencies, PID_LAT and TIMEOUT. Results up to cycle h.
    task automatic model(input int w, input int p, input int a, input int b, input int h);
        int busy_end, tau, dur;
        bit read_ok, write_ok;
        exp_start.delete(); exp_pid.delete(); exp_out.delete(); exp_ovr_tick.delete();
        exp_ovr = 0; exp_smp = 0; exp_tmo = 0;
        read_ok  = (a >= 1) && (a <= TIMEOUT + 1);
        write_ok = (b >= 1) && (b <= TIMEOUT + 1);
        busy_end = w - 1;
        tau = w + p;
        while (tau + 1 <= h) begin
            if (tau <= busy_end) begin
                exp_ovr_tick.push_back(tau);
                if (exp_ovr < 15) exp_ovr++;
            end else begin
                exp_start.push_back(tau + 1);
                if (!read_ok) begin
                    dur = TIMEOUT + 2;
                end else begin
                    if (tau + a + 2 <= h) exp_pid.push_back(tau + a + 2);
                    if (tau + a + 3 + PID_LAT <= h) exp_out.push_back(tau + a + 3 + PID_LAT);
                    dur = a + PID_LAT + 3 + (write_ok ? b : TIMEOUT + 1);
                end
                busy_end = tau + dur;
                if (busy_end + 1 <= h) begin
                    if (read_ok && write_ok) exp_smp++;
                    else exp_tmo = 1;
                end
            end
            tau += p + 1;
        end
        exp_busy = (h <= busy_end) ? 1 : 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        enable = 1'b0;
        while (busy === 1'b1 && n < 2000) begin step(1); n++; end
        check({name, " drain bound"}, 32'(n < 2000), 1);
        step(150);
        check({name, " idle busy"}, 32'(busy), 0);
    endtask

    task automatic run_loop(input string name, input int p, input int a, input int b,
                            input int len, input bit clr);
        int w, h;
        period = p[PERIOD_BITS-1:0];
        in_lat = a;
        out_lat = b;
        if (clr) begin
            clr_status = 1'b1; step(1); clr_status = 1'b0;
            acc_ovr = 0; acc_smp = 0; acc_tmo = 0;
        end
        step(1);
        clear_q();
        enable = 1'b1;
        w = cyc + 1;
        h = w + len;
        goto(h);
        model(w, p, a, b, h);
        cmp_queue({name, " in_start"}, got_start, exp_start);
        cmp_queue({name, " pid_stb"}, got_pid, exp_pid);
        cmp_queue({name, " out_start"}, got_out, exp_out);
        acc_ovr = (acc_ovr + exp_ovr > 15) ? 15 : acc_ovr + exp_ovr;
        acc_smp += exp_smp;
        acc_tmo |= exp_tmo;
        check({name, " overrun_cnt"}, 32'(overrun_cnt), acc_ovr);
        check({name, " overrun"}, 32'(overrun), 32'(acc_ovr > 0));
        check({name, " timeout_err"}, 32'(timeout_err), acc_tmo);
        check({name, " sample_cnt"}, 32'(sample_cnt), acc_smp % 256);
        check({name, " busy"}, 32'(busy), exp_busy);
        drain(name);
        check({name, " no start when off"}, 32'(got_start.size()), 32'(exp_start.size()));
    endtask

    initial begin
        int w, n, tau, c2;
        reset = 1'b1; enable = 1'b0; clr_status = 1'b0; period = 12'd99;
        step(3);
        check("rst in_start", 32'(in_start), 0);
        check("rst pid_stb", 32'(pid_stb), 0);
        check("rst out_start", 32'(out_start), 0);
        check("rst busy", 32'(busy), 0);
        check("rst flags", {30'd0, overrun, timeout_err}, 0);
        check("rst counters", {20'd0, overrun_cnt, sample_cnt}, 0);
        reset = 1'b0;
        step(2);

        run_loop("nominal", 99, 10, 10, 530, 1'b1);
        check("nominal five samples", 32'(sample_cnt), 5);
        check("nominal pid->out gap",
              (got_out.size() > 0 && got_pid.size() > 0) ? got_out[0] - got_pid[0] : -1, PID_LAT + 1);

        for (int i = 0; i < 3; i++)
            run_loop($sformatf("rand%0d", i), $urandom_range(4, 40), $urandom_range(1, 12),
                     $urandom_range(1, 12), 400, 1'b1);
        run_loop("period0", 0, 2, 2, 60, 1'b1);
        run_loop("overrun", 9, 3, 20, 400, 1'b1);
        check("overrun saturated", 32'(overrun_cnt), 15);
        run_loop("rd timeout", 99, 0, 5, 180, 1'b1);
        run_loop("after timeout", 99, 5, 5, 220, 1'b0);
        run_loop("done on expiry", 99, TIMEOUT + 1, 5, 250, 1'b1);
        run_loop("late in_done", 99, TIMEOUT + 2, 5, 250, 1'b1);
        run_loop("wr timeout", 99, 4, 0, 250, 1'b1);

        // Enable dropped during COMPUTE: transaction finishes, nothing new starts.
        period = 12'd49; in_lat = 6; out_lat = 8;
        clr_status = 1'b1; step(1); clr_status = 1'b0; step(1);
        clear_q();
        enable = 1'b1;
        w = cyc + 1;
        model(w, 49, 6, 8, w + 100);
        n = 0;
        while (got_pid.size() == 0 && n < 500) begin step(1); n++; end
        check("drop pid bound", 32'(n < 500), 1);
        enable = 1'b0;
        check("drop pid time", (got_pid.size() > 0) ? got_pid[0] : -1, exp_pid[0]);
        drain("drop");
        check("drop out_start", (got_out.size() > 0) ? got_out[0] : -1, exp_out[0]);
        check("drop sample_cnt", 32'(sample_cnt), 1);
        check("drop single start", 32'(got_start.size()), 1);
        clear_q();
        enable = 1'b1;
        c2 = cyc;
        n = 0;
        while (got_start.size() == 0 && n < 500) begin step(1); n++; end
        check("reenable bound", 32'(n < 500), 1);
        check("reenable start", (got_start.size() > 0) ? got_start[0] : -1, c2 + 1 + 49 + 1);
        drain("reenable");

        // clr_status on the same cycle as an overrun tick.
        period = 12'd9; in_lat = 3; out_lat = 20;
        clr_status = 1'b1; step(1); clr_status = 1'b0; step(1);
        clear_q();
        enable = 1'b1;
        w = cyc + 1;
        model(w, 9, 3, 20, w + 300);
        tau = exp_ovr_tick[1];
        goto(tau);
        check("pre-clr overrun_cnt", 32'(overrun_cnt), 1);
        clr_status = 1'b1; step(1); clr_status = 1'b0;
        check("clr+tick overrun", 32'(overrun), 1);
        check("clr+tick overrun_cnt", 32'(overrun_cnt), 1);
        drain("clr collide");

        // Reset in the middle of WRITE.
        period = 12'd99; in_lat = 3; out_lat = 30;
        step(1);
        clear_q();
        enable = 1'b1;
        n = 0;
        while (got_out.size() == 0 && n < 500) begin step(1); n++; end
        check("rst-write bound", 32'(n < 500), 1);
        step(5);
        reset = 1'b1; enable = 1'b0;
        step(1);
        reset = 1'b0;
        check("midrst busy", 32'(busy), 0);
        check("midrst pulses", {29'd0, in_start, pid_stb, out_start}, 0);
        check("midrst flags", {30'd0, overrun, timeout_err}, 0);
        check("midrst counters", {20'd0, overrun_cnt, sample_cnt}, 0);
        clear_q();
        step(60);
        check("postrst pulses", 32'(got_start.size() + got_pid.size() + got_out.size()), 0);
        check("postrst sample_cnt", 32'(sample_cnt), 0);
        check("postrst busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pid_sequencer.md
# pid_sequencer

Loop scheduler for the PID controller. It turns a programmable sample period into a strictly ordered transaction: read process value over the SPI input master, strobe the PID core, then write the stimulus over the SPI output master. It replaces free-running strobe wiring with explicit handshakes, overrun detection and per-phase timeouts. Sits between the configuration registers and the SPI masters and PID core in the top-level wrapper.

## Interface
Parameters:
- `PERIOD_BITS`, 12: width of the sample-period reload value.
- `PID_LAT`, 2: cycles from `pid_stb` to a valid stimulus, 1..15.
- `TIMEOUT`, 63: maximum cycles spent waiting for `in_done` or `out_done`, 1..255.

Ports (clock and reset first):
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: run the loop.
- `period` in PERIOD_BITS: reload value; tick interval is `period`+1 cycles.
- `clr_status` in 1: clears the sticky flags and counters.
- `in_start` out 1: one-cycle start pulse to the SPI input master.
- `in_done` in 1: one-cycle pulse; the PV word is captured.
- `pid_stb` out 1: one-cycle strobe to the PID core.
- `out_start` out 1: one-cycle start pulse to the SPI output master.
- `out_done` in 1: one-cycle pulse; the stimulus has been shifted out.
- `busy` out 1: high in READ, COMPUTE and WRITE.
- `overrun` out 1: sticky; a tick arrived while not in WAIT.
- `timeout_err` out 1: sticky; a phase timed out.
- `overrun_cnt` out 4: saturating count of dropped ticks.
- `sample_cnt` out 8: wrapping count of completed transactions.

## Operation
- States: IDLE, WAIT, READ, COMPUTE, WRITE.
- Period counter:
  - Down-counter that reloads from `period` when it reaches 0, or while in IDLE or reset.
  - `tick` = (count==0) and the state is not IDLE.
- IDLE: if `enable` -> WAIT.
- WAIT:
  - `tick` -> READ.
  - `!enable` (no tick) -> IDLE.
  - `tick` and `!enable` in the same cycle -> IDLE; the tick is dropped without an overrun.
- READ:
  - `in_done` -> COMPUTE.
  - Wait counter reaching TIMEOUT -> set `timeout_err`, go to WAIT, no `pid_stb`.
- COMPUTE: lasts PID_LAT cycles after the `pid_stb` cycle, then -> WRITE.
- WRITE:
  - `out_done` -> WAIT and `sample_cnt`+1.
  - Timeout -> set `timeout_err`, go to WAIT, no count increment.
- `enable` low during READ, COMPUTE or WRITE: the current transaction completes (or times out) first, then WAIT falls through to IDLE.
- Overrun: `tick` in READ, COMPUTE or WRITE sets `overrun` and increments `overrun_cnt` (saturates at 15). The tick is discarded, not queued.
- Simultaneous events:
  - done and timeout in the same cycle: done wins, no error.
  - `tick` and `out_done` in the same cycle: counts as an overrun; state still -> WAIT.
  - `clr_status` and a new event in the same cycle: the event wins, leaving the flag set and the count at 1 (`sample_cnt` is not cleared that cycle).
- `in_done`/`out_done` outside their own states are ignored.
- `reset` mid-transaction aborts it immediately and emits no further pulses.

## Timing
- All outputs are registered.
- Reset values: state IDLE; all pulses, `busy`, flags and counters 0.
- Tick in cycle t (state WAIT) -> `in_start` high in cycle t+1 only; `busy` high from t+1.
- `in_done` in cycle t -> `pid_stb` high in t+1 only.
- `pid_stb` in cycle t -> `out_start` high in t+1+PID_LAT.
- `out_done` in cycle t -> state WAIT and `busy` low in t+1; `sample_cnt` updates in t+1.
- Timeout: the wait counter starts at 0 in the cycle after the start pulse. Expiry in the cycle the counter equals TIMEOUT with no done pulse -> WAIT in the next cycle.
- Minimum transaction length: 1 (start) + done latency + 1 + PID_LAT + 1 + done latency.
- `period`=0 -> a tick every cycle; every tick during a transaction is an overrun.
- `period` changes take effect at the next reload.

## Test plan
- Nominal loop: `period`=99, PID_LAT=2, `in_done` 10 cycles after `in_start`, `out_done` 10 cycles after `out_start` -> `in_start` every 100 cycles, `out_start` exactly 3 cycles after `pid_stb`, `sample_cnt`=5 after 5 periods, no flags.
- Overrun: `period`=9, `out_done` delayed 20 cycles -> `overrun`=1, `overrun_cnt` increments once per dropped tick and saturates at 15, no double `in_start`.
- Timeout: never assert `in_done`, TIMEOUT=63 -> `timeout_err`=1, no `pid_stb`, state WAIT. A later good transaction increments `sample_cnt`.
- Enable drop: deassert `enable` during COMPUTE -> `out_start` still issues, `out_done` completes, then IDLE. No `in_start` while disabled; the period counter holds at `period`.
- Collisions:
  - `in_done` on the exact timeout cycle -> no error and `pid_stb` follows.
  - `clr_status` together with an overrun tick -> `overrun`=1 and `overrun_cnt`=1.
- Reset mid-WRITE -> all outputs 0 in the next cycle, state IDLE, and no `out_done` response afterwards.
